// File: rtl/psg_write_sched_if.sv
// CPU write port and shared PSG bus of the write scheduler.
// master = CPU/PSG side, slave = scheduler side.
interface psg_write_sched_if #(
  parameter int NUM_CHIPS = 3
);
  logic                 wr_valid;
  logic [2:0]           wr_chip;
  logic [7:0]           wr_data;
  logic                 wr_ready;
  logic [NUM_CHIPS-1:0] sn_ready;
  logic [NUM_CHIPS-1:0] sn_ce_n;
  logic [7:0]           sn_d;

  modport master (
    output wr_valid, wr_chip, wr_data, sn_ready,
    input  wr_ready, sn_ce_n, sn_d
  );

  modport slave (
    input  wr_valid, wr_chip, wr_data, sn_ready,
    output wr_ready, sn_ce_n, sn_d
  );
endinterface

// File: rtl/psg_write_sched.sv
// Queued Z80->PSG write scheduler: FIFO plus one CE/READY handshake per entry.
// Optional handshake timeout with macro PSG_WR_TIMEOUT_EN; without it STROBE/HOLD wait forever.
module psg_write_sched #(
  parameter int NUM_CHIPS  = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk_14m,
  input  logic                        reset,
  psg_write_sched_if.slave            bus,
  input  logic                        clr_err,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [2:0]                  err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  if (NUM_CHIPS < 1 || NUM_CHIPS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("psg_write_sched: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RELEASE} state_t;

  state_t               state_q;
  logic [2:0]           chip_q;
  logic [7:0]           sn_d_q;
  logic [NUM_CHIPS-1:0] ce_n_q;

  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    err_q, err_d;

  logic                 wr_ready, push, pop, overflow;
  logic                 head_vld, head_bad, bad_pop, tmo_hit;
  logic [10:0]          head;
  logic                 ready_sel;
  logic [NUM_CHIPS-1:0] ce_sel_n;

  assign wr_ready = (level_q != LW'(FIFO_DEPTH));
  assign push     = bus.wr_valid & wr_ready;
  assign overflow = bus.wr_valid & ~wr_ready;
  assign head_vld = (level_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign head_bad = ({1'b0, head[10:8]} >= 4'(NUM_CHIPS));
  assign bad_pop  = (state_q == IDLE) && head_vld && head_bad;
  assign pop      = bad_pop || (state_q == RELEASE) || tmo_hit;

`ifdef PSG_WR_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign tmo_hit = ((state_q == STROBE) || (state_q == HOLD)) && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk_14m or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == STROBE) || (state_q == HOLD)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Target-chip decode; sn_ready of every other chip is ignored.
  always_comb begin
    ready_sel = 1'b1;
    ce_sel_n  = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (chip_q == 3'(i)) begin
        ready_sel   = bus.sn_ready[i];
        ce_sel_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A new error beats a simultaneous clear.
    err_d = (clr_err ? 3'b000 : err_q) | {tmo_hit, bad_pop, overflow};
  end

  always_ff @(posedge clk_14m) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.wr_chip, bus.wr_data};
    end
  end

  always_ff @(posedge clk_14m or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // The entry stays at the FIFO head for the whole handshake and is popped on exit.
  always_ff @(posedge clk_14m or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      chip_q  <= '0;
      sn_d_q  <= '0;
      ce_n_q  <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_vld && !head_bad) begin
            chip_q  <= head[10:8];
            sn_d_q  <= head[7:0];
            state_q <= SETUP;
          end
        end
        SETUP: begin
          ce_n_q  <= ce_sel_n;
          state_q <= STROBE;
        end
        STROBE: begin
          if (tmo_hit) begin
            ce_n_q  <= '1;
            state_q <= IDLE;
          end else if (!ready_sel) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tmo_hit) begin
            ce_n_q  <= '1;
            state_q <= IDLE;
          end else if (ready_sel) begin
            ce_n_q  <= '1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          ce_n_q  <= '1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.sn_ce_n  = ce_n_q;
  assign bus.sn_d     = sn_d_q;
  assign busy         = (state_q != IDLE) || head_vld;
  assign fifo_level   = level_q;
  assign err          = err_q;
endmodule

// File: tb/tb_psg_write_sched.sv
// Directed bench for psg_write_sched: PSG model holds READY low 4 cycles after CE unless stuck.
module tb_psg_write_sched;
  localparam int NC  = 3;
  localparam int FD  = 8;
  localparam int TMO = 16;

  logic       clk_14m = 1'b0;
  logic       reset   = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy;
  logic [3:0] fifo_level;
  logic [2:0] err;

  int checks = 0;
  int errors = 0;

  psg_write_sched_if #(.NUM_CHIPS(NC)) bus ();

  psg_write_sched #(.NUM_CHIPS(NC), .FIFO_DEPTH(FD), .TIMEOUT(TMO)) dut (
    .clk_14m    (clk_14m),
    .reset      (reset),
    .bus        (bus),
    .clr_err    (clr_err),
    .busy       (busy),
    .fifo_level (fifo_level),
    .err        (err)
  );

  always #5 clk_14m = ~clk_14m;

  logic [NC-1:0] stuck    = '0;
  logic [NC-1:0] prev_ce  = '1;
  int            mcnt [NC];
  int            multi_ce = 0;
  logic [7:0]    rx_dat [$];
  int            rx_chip [$];

  // PSG model and bus monitor, evaluated away from the active edge.
  always @(negedge clk_14m) begin
    for (int k = 0; k < NC; k++) begin
      if (bus.sn_ce_n[k] == 1'b0 && !stuck[k]) begin
        bus.sn_ready[k] = (mcnt[k] >= 4);
        mcnt[k]++;
      end else begin
        bus.sn_ready[k] = 1'b1;
        mcnt[k] = 0;
      end
      if (prev_ce[k] && !bus.sn_ce_n[k]) begin
        rx_dat.push_back(bus.sn_d);
        rx_chip.push_back(k);
      end
    end
    if ($countones(~bus.sn_ce_n) > 1) multi_ce++;
    prev_ce = bus.sn_ce_n;
  end

  task automatic step();
    @(posedge clk_14m);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.wr_valid = 1'b0;
    bus.wr_chip  = 3'd0;
    bus.wr_data  = 8'h00;
    reset        = 1'b0;
    #23;
    reset = 1'b1;
    step();
    checks++; if (bus.sn_ce_n !== 3'b111) begin errors++; $display("FAIL reset_ce_n got %b want 111", bus.sn_ce_n); end
    checks++; if (bus.sn_d !== 8'h00) begin errors++; $display("FAIL reset_sn_d got %h want 00", bus.sn_d); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", err); end
  endtask

  task automatic test_single_write();
    int n;
    rx_dat.delete(); rx_chip.delete();
    bus.wr_valid = 1'b1; bus.wr_chip = 3'd1; bus.wr_data = 8'h9F;
    step();
    bus.wr_valid = 1'b0;
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level_e0 got %0d want 1", fifo_level); end
    checks++; if (bus.sn_ce_n !== 3'b111) begin errors++; $display("FAIL single_ce_e0 got %b want 111", bus.sn_ce_n); end
    step();
    checks++; if (bus.sn_d !== 8'h9F) begin errors++; $display("FAIL single_sn_d_e1 got %h want 9f", bus.sn_d); end
    checks++; if (bus.sn_ce_n !== 3'b111) begin errors++; $display("FAIL single_ce_e1 got %b want 111", bus.sn_ce_n); end
    step();
    checks++; if (bus.sn_ce_n !== 3'b101) begin errors++; $display("FAIL single_ce_e2 got %b want 101", bus.sn_ce_n); end
    n = 1;
    while (bus.sn_ce_n !== 3'b111 && n < 100) begin
      step();
      if (bus.sn_ce_n !== 3'b111) n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL single_ce_low_cycles got %0d want 5", n); end
    checks++; if (fifo_level !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_release_state got level %0d busy %b want 1 1", fifo_level, busy); end
    step();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level_end got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL single_err got %b want 000", err); end
    checks++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'h9F || rx_chip[0] != 1) begin errors++; $display("FAIL single_rx got %0d entries want 1 (chip1 9f)", rx_dat.size()); end
  endtask

  task automatic test_burst();
    int n;
    rx_dat.delete(); rx_chip.delete();
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_chip  = (i % 2 == 1) ? 3'd2 : 3'd0;
      bus.wr_data  = 8'(i);
      step();
    end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL burst_wr_ready_full got %b want 0", bus.wr_ready); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL burst_level_full got %0d want 8", fifo_level); end
    bus.wr_chip = 3'd0; bus.wr_data = 8'hAA;
    step();
    bus.wr_valid = 1'b0;
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL burst_overflow_err got %b want 001", err); end
    checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL burst_level_after_drop got %0d want 7", fifo_level); end
    wait_idle(400, n);
    checks++; if (n >= 400) begin errors++; $display("FAIL burst_drain_timeout got busy %b want 0", busy); end
    checks++; if (rx_dat.size() != 8) begin errors++; $display("FAIL burst_rx_count got %0d want 8", rx_dat.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_dat[i] !== 8'(i) || rx_chip[i] != ((i % 2 == 1) ? 2 : 0)) begin
        errors++; $display("FAIL burst_rx_order[%0d] got chip %0d data %h want chip %0d data %h",
                           i, rx_chip[i], rx_dat[i], (i % 2 == 1) ? 2 : 0, 8'(i));
      end
    end
    checks++; if (multi_ce != 0) begin errors++; $display("FAIL burst_multi_ce got %0d want 0", multi_ce); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic test_bad_index();
    int n;
    rx_dat.delete(); rx_chip.delete();
    bus.wr_valid = 1'b1; bus.wr_chip = 3'd5; bus.wr_data = 8'h55;
    step();
    bus.wr_chip = 3'd1; bus.wr_data = 8'h11;
    step();
    bus.wr_valid = 1'b0;
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL bad_err got %b want 010", err); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL bad_level got %0d want 1", fifo_level); end
    checks++; if (bus.sn_ce_n !== 3'b111) begin errors++; $display("FAIL bad_ce got %b want 111", bus.sn_ce_n); end
    wait_idle(100, n);
    checks++; if (n >= 100) begin errors++; $display("FAIL bad_drain_timeout got busy %b want 0", busy); end
    checks++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'h11 || rx_chip[0] != 1) begin errors++; $display("FAIL bad_rx got %0d entries want 1 (chip1 11)", rx_dat.size()); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    rx_dat.delete(); rx_chip.delete();
    stuck = 3'b001;
    bus.wr_valid = 1'b1; bus.wr_chip = 3'd0; bus.wr_data = 8'h3C;
    step();
    bus.wr_chip = 3'd2; bus.wr_data = 8'h5A;
    step();
    bus.wr_valid = 1'b0;
    step();
    checks++; if (bus.sn_ce_n !== 3'b110) begin errors++; $display("FAIL tmo_ce_start got %b want 110", bus.sn_ce_n); end
    n = 1;
`ifdef PSG_WR_TIMEOUT_EN
    while (bus.sn_ce_n !== 3'b111 && n < 60) begin
      step();
      if (bus.sn_ce_n !== 3'b111) n++;
    end
    checks++; if (n != TMO) begin errors++; $display("FAIL tmo_ce_low_cycles got %0d want %0d", n, TMO); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL tmo_err got %b want 100", err); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL tmo_level got %0d want 1", fifo_level); end
`else
    while (bus.sn_ce_n === 3'b110 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n != 40 || bus.sn_ce_n !== 3'b110) begin errors++; $display("FAIL tmo_ce_held got %0d cycles ce %b want 40 110", n, bus.sn_ce_n); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL tmo_err_off got %b want 000", err); end
`endif
    stuck = 3'b000;
    wait_idle(200, n);
    checks++; if (n >= 200) begin errors++; $display("FAIL tmo_drain_timeout got busy %b want 0", busy); end
    checks++; if (rx_dat.size() != 2 || rx_chip[0] != 0 || rx_dat[1] !== 8'h5A || rx_chip[1] != 2) begin errors++; $display("FAIL tmo_rx got %0d entries want 2 (chip0 3c, chip2 5a)", rx_dat.size()); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_chip = 3'd1; bus.wr_data = 8'hA1 + 8'(i);
      step();
    end
    bus.wr_valid = 1'b0;
    step();
    step();
    checks++; if (bus.sn_ce_n !== 3'b101 || fifo_level !== 4'd3) begin errors++; $display("FAIL hold_pre got ce %b level %0d want 101 3", bus.sn_ce_n, fifo_level); end
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.sn_ce_n !== 3'b111) begin errors++; $display("FAIL hold_rst_ce got %b want 111", bus.sn_ce_n); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL hold_rst_level got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_rst_busy got %b want 0", busy); end
    #1 reset = 1'b1;
    rx_dat.delete(); rx_chip.delete();
    repeat (20) step();
    checks++; if (rx_dat.size() != 0) begin errors++; $display("FAIL hold_stale_writes got %0d want 0", rx_dat.size()); end
    checks++; if (bus.sn_ce_n !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL hold_after got ce %b busy %b want 111 0", bus.sn_ce_n, busy); end
  endtask

  task automatic test_clr_err();
    int n;
    rx_dat.delete(); rx_chip.delete();
    stuck = 3'b001;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_chip = 3'd0; bus.wr_data = 8'hC0 + 8'(i);
      step();
    end
    bus.wr_data = 8'hFF;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    bus.wr_valid = 1'b0;
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL clr_vs_overflow got err %b want bit0 set", err); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL clr_alone got %b want 000", err); end
    stuck = 3'b000;
    wait_idle(400, n);
    checks++; if (n >= 400 || fifo_level !== 4'd0) begin errors++; $display("FAIL clr_drain got level %0d busy %b want 0 0", fifo_level, busy); end
    checks++; if (rx_dat.size() != 8) begin errors++; $display("FAIL clr_rx_count got %0d want 8", rx_dat.size()); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_bad_index();
    test_timeout();
    test_reset_in_hold();
    test_clr_err();
    checks++; if (multi_ce != 0) begin errors++; $display("FAIL final_multi_ce got %0d want 0", multi_ce); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/psg_write_sched.md
Name: psg_write_sched

Overview:
- Parametrised write scheduler between the sound Z80 bus and NUM_CHIPS SN76489-class PSGs.
- Replaces a single shared data latch plus per-chip READY-gated chip enables with a write FIFO. The CPU never waits on PSG READY.
- Drains entries one at a time with a full CE/READY handshake per chip.
- Reports overflow, bad-index and timeout errors.

Parameters:
- NUM_CHIPS, 3, number of PSGs served (1..8).
- FIFO_DEPTH, 8, write queue entries (power of 2, 2..64).
- TIMEOUT, 255, clk_14m cycles allowed per handshake before abort (1..65535).

Ports:
- clk_14m  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  CPU write request, sampled every cycle.
- wr_chip  in  3  target chip index.
- wr_data  in  8  byte for PSG.
- wr_ready  out  1  FIFO not full.
- sn_ready  in  NUM_CHIPS  PSG READY outputs; low = busy.
- sn_ce_n  out  NUM_CHIPS  PSG chip enables, active-low.
- sn_d  out  8  shared PSG data bus.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued.
- err  out  3  sticky flags: [0] overflow, [1] bad chip index, [2] timeout.
- clr_err  in  1  clears err on the next edge.

Behaviour:
- Reset values:
  - sn_ce_n all 1; sn_d 8'h00; wr_ready 1; busy 0; fifo_level 0; err 0.
  - FIFO pointers 0; FSM IDLE; timeout counter 0.
- Push:
  - Occurs when wr_valid & wr_ready; stores {wr_chip, wr_data}.
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
- Overflow: wr_valid while full drops the write and sets err[0]. This holds even if a pop happens the same cycle.
- Push and pop in the same cycle (not full): fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, SETUP, STROBE, HOLD, RELEASE.
- IDLE:
  - If FIFO is non-empty, load the head entry into a working register.
  - If chip index >= NUM_CHIPS: pop, set err[1], stay IDLE (no strobe).
  - Otherwise go to SETUP.
- SETUP: sn_d = working data; all sn_ce_n high; 1 cycle. Data is stable for at least 1 cycle before CE.
- STROBE:
  - sn_ce_n[k] = 0; clear the timeout counter on entry.
  - Go to HOLD when sn_ready[k] == 0 is sampled (chip acknowledged).
- HOLD: keep sn_ce_n[k] = 0 and sn_d stable. Go to RELEASE when sn_ready[k] == 1 is sampled.
- RELEASE: sn_ce_n all high; pop FIFO head; go to IDLE (1 cycle).
- Minimum cycles per write: IDLE→SETUP→STROBE(≥1)→HOLD(≥1)→RELEASE. The next SETUP cannot start until 1 cycle after RELEASE.
- Latency: push accepted at edge 0 into an empty FIFO in IDLE:
  - fifo_level = 1 after edge 0.
  - SETUP after edge 1; sn_d valid after edge 1.
  - sn_ce_n[k] low after edge 2.
- Timeout (see Optional Feature):
  - The counter increments each cycle in STROBE/HOLD.
  - On reaching TIMEOUT: sn_ce_n high, pop entry, set err[2], go IDLE.
- sn_ready of non-target chips is ignored. Only one sn_ce_n bit is ever low.
- clr_err has priority under set: if clr_err and a new error occur in the same cycle, the flag ends up set.
- Asynchronous reset mid-handshake:
  - CE releases immediately and the FIFO contents are discarded.
  - No partial write is retried.
- sn_d holds its last value in IDLE; it does not return to 0.

Optional Feature:
- Macro: PSG_WR_TIMEOUT_EN.
- Defined: timeout counter present; behaviour as above; err[2] live.
- Undefined: no counter; STROBE/HOLD wait indefinitely on sn_ready; err[2] tied 0; TIMEOUT parameter unused.

Test Plan:
- Single write. Stimulus: push chip 1, data 8'h9F; model chip 1 READY low for 4 cycles after CE.
  Required: sn_d=9F after edge 1; sn_ce_n=3'b101 after edge 2 until RELEASE; fifo_level 1→0; busy falls after RELEASE; err=0.
- Burst ordering. Stimulus: 8 back-to-back pushes to chips 0,2,0,2,... with data 00..07.
  Required: wr_ready low after the 8th; a 9th push sets err[0] and is dropped; PSG receive order 00..07; never two CE low at once.
- Bad index. Stimulus: push chip 5 with NUM_CHIPS=3.
  Required: no CE activity; entry popped; err[1]=1; a subsequent valid write still executes.
- Timeout (PSG_WR_TIMEOUT_EN, TIMEOUT=16). Stimulus: chip 0 READY stuck high.
  Required: CE low for 16 cycles then high; err[2]=1; FIFO advances. With the macro undefined, CE stays low indefinitely.
- Reset during HOLD with 3 entries queued.
  Required: sn_ce_n all 1 asynchronously; fifo_level 0; busy 0; after release, no stale writes are issued.
- clr_err in the same cycle as an overflow.
  Required: err[0] remains 1. clr_err alone on the next cycle: err = 0.
